// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-add multiplier scheduler.
package mult_pkg;

    localparam int DEFAULT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADD,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; i_ptr names the requester served last, so the other one wins a tie.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = i_ptr ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mult_scheduler.sv
// Sequences a shared W-bit shift-add multiplier between two requesters.
// Every output is decoded from the registered state and owner, plus m while in ADD.
module mult_scheduler
    import mult_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       sel,
    input  logic       m,
    output logic       load,
    output logic       ad,
    output logic       sh,
    output logic [1:0] done,
    output logic       idle
);

    localparam int            CW   = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W);

    state_t        r_state;
    state_t        w_nextState;
    logic          r_owner;
    logic          w_nextOwner;
    logic          r_ptr;
    logic          w_nextPtr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_nextCount;
    logic [CW-1:0] w_countInc;
    logic [1:0]    w_arbGnt;
    logic [1:0]    w_ownerOneHot;

    rr_arb2 u_arb (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_arbGnt)
    );

    assign w_ownerOneHot = r_owner ? 2'b10 : 2'b01;
    assign w_countInc    = r_count + CW'(1);

    // Pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_ptr   <= 1'b1;
            r_count <= '0;
        end else begin
            r_state <= w_nextState;
            r_owner <= w_nextOwner;
            r_ptr   <= w_nextPtr;
            r_count <= w_nextCount;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextOwner = r_owner;
        w_nextPtr   = r_ptr;
        w_nextCount = r_count;
        gnt         = 2'b00;
        sel         = 1'b0;
        load        = 1'b0;
        ad          = 1'b0;
        sh          = 1'b0;
        done        = 2'b00;
        idle        = 1'b0;

        if (r_state != IDLE) begin
            gnt = w_ownerOneHot;
            sel = r_owner;
        end

        case (r_state)
            IDLE: begin
                idle = 1'b1;
                if (req != 2'b00) begin
                    w_nextOwner = (w_arbGnt == 2'b10);
                    w_nextCount = '0;
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                load        = 1'b1;
                w_nextState = ADD;
            end
            ADD: begin
                ad          = m;
                w_nextState = SHIFT;
            end
            SHIFT: begin
                sh          = 1'b1;
                w_nextCount = w_countInc;
                w_nextState = (w_countInc == LAST) ? DONE : ADD;
            end
            DONE: begin
                done        = w_ownerOneHot;
                w_nextPtr   = r_owner;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench for mult_scheduler: W=4 and W=8 instances, cycle-by-cycle output vector checks.
module tb_mult_scheduler;

    // Output vector layout: {gnt[1:0], sel, load, ad, sh, done[1:0], idle}
    localparam logic [8:0] IDLE_VEC = 9'b00_0_0_0_0_00_1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req4, req8;
    logic       m4, m8;
    logic [1:0] gnt4, gnt8, done4, done8;
    logic       sel4, sel8, load4, load8, ad4, ad8, sh4, sh8, idle4, idle8;

    int nChecks = 0;
    int nPassed = 0;

    always #5 clk = ~clk;

    mult_scheduler #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .gnt(gnt4), .sel(sel4), .m(m4),
        .load(load4), .ad(ad4), .sh(sh4), .done(done4), .idle(idle4)
    );

    mult_scheduler #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .gnt(gnt8), .sel(sel8), .m(m8),
        .load(load8), .ad(ad8), .sh(sh8), .done(done8), .idle(idle8)
    );

    function automatic logic [8:0] obs(input bit which);
        if (which)
            return {gnt8, sel8, load8, ad8, sh8, done8, idle8};
        return {gnt4, sel4, load4, ad4, sh4, done4, idle4};
    endfunction

    // Cycle c counts clock periods after the grant-latching edge (LOAD is cycle 1, DONE is 2w+2).
    function automatic logic [8:0] expVec(input int c, input int w, input bit owner, input logic [7:0] mSeq);
        logic [1:0] oh;
        logic       ld, a, s;
        logic [1:0] d;
        oh = owner ? 2'b10 : 2'b01;
        ld = (c == 1);
        a  = ((c % 2 == 0) && c >= 2 && c <= 2 * w) ? mSeq[c / 2 - 1] : 1'b0;
        s  = ((c % 2 == 1) && c >= 3 && c <= 2 * w + 1);
        d  = (c == 2 * w + 2) ? oh : 2'b00;
        return {oh, owner, ld, a, s, d, 1'b0};
    endfunction

    task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected);
        nChecks++;
        assert (observed === expected) nPassed++;
        else $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    endtask

    task automatic applyStimulus(input bit which, input logic [1:0] r, input logic mv);
        if (which) begin
            req8 = r;
            m8   = mv;
        end else begin
            req4 = r;
            m4   = mv;
        end
    endtask

    // m is held high outside ADD cycles so a leaking ad shows up.
    task automatic runOp(input bit which, input int w, input logic [1:0] reqIn, input logic [7:0] mSeq,
                         input bit owner, input int dropAt, input int raiseAt,
                         input logic [1:0] clearAtDone, input string tag);
        logic [1:0] r;
        logic [1:0] oh;
        r  = reqIn;
        oh = owner ? 2'b10 : 2'b01;
        applyStimulus(which, r, 1'b1);
        for (int c = 1; c <= 2 * w + 2; c++) begin
            @(negedge clk);
            if (c == dropAt)    r = r & ~oh;
            if (c == raiseAt)   r = r | ~oh;
            if (c == 2 * w + 2) r = r & ~clearAtDone;
            applyStimulus(which, r, ((c % 2 == 0) && c <= 2 * w) ? mSeq[c / 2 - 1] : 1'b1);
            #1 checkOutput($sformatf("%s c%0d", tag, c), obs(which), expVec(c, w, owner, mSeq));
        end
        @(negedge clk);
        #1 checkOutput($sformatf("%s idle", tag), obs(which), IDLE_VEC);
    endtask

    initial begin
        rst_n = 1'b1;
        req4  = 2'b00;
        req8  = 2'b00;
        m4    = 1'b0;
        m8    = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset4", obs(1'b0), IDLE_VEC);
        checkOutput("reset8", obs(1'b1), IDLE_VEC);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("postReset4", obs(1'b0), IDLE_VEC);
        checkOutput("postReset8", obs(1'b1), IDLE_VEC);

        // Both requesters held high: 0, then 1, then 0 again.
        runOp(1'b0, 4, 2'b11, 8'h05, 1'b0, 0, 0, 2'b00, "tie0");
        runOp(1'b0, 4, 2'b11, 8'h0A, 1'b1, 0, 0, 2'b00, "tie1");
        runOp(1'b0, 4, 2'b11, 8'h03, 1'b0, 0, 0, 2'b11, "tie2");

        // Single request, m = 1,0,1,1 on successive ADD visits.
        runOp(1'b0, 4, 2'b01, 8'h0D, 1'b0, 0, 0, 2'b01, "basic");

        // Reset while in SHIFT: outputs clear at once and no done follows.
        applyStimulus(1'b0, 2'b01, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #1 checkOutput($sformatf("preRst c%0d", c), obs(1'b0), expVec(c, 4, 1'b0, 8'hFF));
        end
        rst_n = 1'b0;
        #1 checkOutput("rstShift", obs(1'b0), IDLE_VEC);
        applyStimulus(1'b0, 2'b00, 1'b0);
        @(negedge clk);
        #1 checkOutput("rstHeld", obs(1'b0), IDLE_VEC);
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #1 checkOutput($sformatf("postRst c%0d", c), obs(1'b0), IDLE_VEC);
        end
        // Pointer was left at 0 before reset; a reset pointer must still favour requester 0.
        runOp(1'b0, 4, 2'b11, 8'h09, 1'b0, 0, 0, 2'b11, "rstTie");

        // Requester 1 drops req after two cycles; the operation still completes.
        runOp(1'b0, 4, 2'b10, 8'h06, 1'b1, 2, 0, 2'b10, "drop");

        // Requester 1 arrives mid-operation and waits for DONE plus an IDLE cycle.
        runOp(1'b0, 4, 2'b01, 8'h0B, 1'b0, 0, 5, 2'b01, "busy0");
        runOp(1'b0, 4, 2'b10, 8'h0E, 1'b1, 0, 0, 2'b10, "late1");

        // Wider datapath: 8 shifts, done in cycle 18.
        runOp(1'b1, 8, 2'b01, 8'hA5, 1'b0, 0, 0, 2'b01, "w8");

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
